// File: rtl/pre_emphasis_arbiter.sv
// Round-robin shared pre-emphasis filter y = x - ALPHA*x[n-1] over NUM_CH channels,
// with per-channel history and one registered, tagged output beat per cycle.
module pre_emphasis_arbiter #(
    parameter int          SAMPLE_WIDTH = 16,
    parameter logic [15:0] ALPHA        = 16'd31785,
    parameter int          NUM_CH       = 4,
    localparam int         CH_W         = $clog2(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              in_valid,
    output logic [NUM_CH-1:0]              in_ready,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] x_in,
    input  logic [NUM_CH-1:0]              flush_ch,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SAMPLE_WIDTH-1:0]        y_out,
    output logic [CH_W-1:0]                out_ch,
    output logic                           sat_event
);
    localparam int SW = SAMPLE_WIDTH;
    localparam int PW = SW + 18;
    localparam int DW = SW + 2;

    logic [CH_W-1:0]      ptr;
    logic [CH_W-1:0]      grant;
    logic                 found;
    logic                 slot_free;
    logic                 accept;
    int                   idx;
    logic signed [SW-1:0] hist [NUM_CH];

    logic signed [SW-1:0] x_sel;
    logic signed [SW-1:0] hist_sel;
    logic signed [16:0]   coef;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;
    logic signed [DW-1:0] diff;
    logic                 sat;
    logic [SW-1:0]        y_next;

    assign slot_free = !out_valid || out_ready;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                grant = CH_W'(idx);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (found && slot_free && rst_n) in_ready[grant] = 1'b1;
    end

    assign accept = |in_ready;

    // A flush on the granted channel zeroes the history used in this beat.
    always_comb begin
        x_sel    = $signed(x_in[int'(grant)*SW +: SW]);
        hist_sel = flush_ch[grant] ? '0 : hist[grant];
        coef     = $signed({1'b0, ALPHA});
        prod     = hist_sel * coef;
        scaled   = prod >>> 15;
        diff     = $signed({{2{x_sel[SW-1]}}, x_sel}) - $signed(scaled[DW-1:0]);
        sat      = (diff[DW-1:SW-1] != '0) && (diff[DW-1:SW-1] != '1);
        if (!sat)
            y_next = diff[SW-1:0];
        else if (diff[DW-1])
            y_next = {1'b1, {(SW-1){1'b0}}};
        else
            y_next = {1'b0, {(SW-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y_out     <= '0;
            out_ch    <= '0;
            sat_event <= 1'b0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y_out     <= y_next;
            out_ch    <= grant;
            sat_event <= sat;
            ptr       <= (grant == CH_W'(NUM_CH-1)) ? '0 : grant + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_hist
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                hist[i] <= '0;
            else if (accept && grant == CH_W'(i))
                hist[i] <= $signed(x_in[i*SW +: SW]);
            else if (flush_ch[i])
                hist[i] <= '0;
        end
    end
endmodule

// File: tb/tb_pre_emphasis_arbiter.sv
// Bench for pre_emphasis_arbiter: a cycle model predicts grants and queues expected
// beats; a negedge monitor pops them on each output handshake.
module tb_pre_emphasis_arbiter;
    localparam int SW = 16;
    localparam int N  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          in_valid;
    logic [N-1:0]          in_ready;
    logic [N-1:0][SW-1:0]  xs;
    logic [N*SW-1:0]       x_in;
    logic [N-1:0]          flush_ch;
    logic                  out_valid;
    logic                  out_ready;
    logic [SW-1:0]         y_out;
    logic [1:0]            out_ch;
    logic                  sat_event;

    assign x_in = xs;
    always #5 clk = ~clk;

    pre_emphasis_arbiter #(.SAMPLE_WIDTH(SW), .ALPHA(16'd31785), .NUM_CH(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .flush_ch(flush_ch), .out_valid(out_valid), .out_ready(out_ready),
        .y_out(y_out), .out_ch(out_ch), .sat_event(sat_event)
    );

    typedef struct { int ch; int y; bit sat; } beat_t;
    beat_t sb[$];
    int checks = 0;
    int errors = 0;

    int     mh [N];
    int     mptr;
    bit     mov;
    bit     m_found, m_slot, m_sat;
    int     m_g, m_y, m_h;
    logic [N-1:0] m_pred;
    beat_t  m_b;

    function automatic void model_calc(input int x, input int h, output int y, output bit s);
        longint p, sc, d;
        p  = longint'(h) * 64'sd31785;
        sc = p >>> 15;
        d  = longint'(x) - sc;
        if (d > 32767)       begin y = 32767;  s = 1'b1; end
        else if (d < -32768) begin y = -32768; s = 1'b1; end
        else                 begin y = int'(d); s = 1'b0; end
    endfunction

    // Model and scoreboard: inputs are stable between posedge+1 and the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mov = 1'b0;
            mptr = 0;
            for (int i = 0; i < N; i++) mh[i] = 0;
            sb.delete();
        end else begin
            checks++;
            if (out_valid !== mov) begin
                errors++;
                $display("FAIL out_valid: got %b want %b at %0t", out_valid, mov, $time);
            end
            if (mov && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL beat: unexpected output beat at %0t", $time);
                end else begin
                    m_b = sb.pop_front();
                    if (int'($signed(y_out)) != m_b.y || int'(out_ch) != m_b.ch || sat_event !== m_b.sat) begin
                        errors++;
                        $display("FAIL beat: got y=%0d ch=%0d sat=%b want y=%0d ch=%0d sat=%b at %0t",
                                 $signed(y_out), out_ch, sat_event, m_b.y, m_b.ch, m_b.sat, $time);
                    end
                end
            end
            m_slot  = !mov || out_ready;
            m_found = 1'b0;
            m_g     = 0;
            for (int k = 0; k < N; k++) begin
                if (!m_found && in_valid[(mptr + k) % N]) begin
                    m_found = 1'b1;
                    m_g     = (mptr + k) % N;
                end
            end
            m_pred = '0;
            if (m_found && m_slot) m_pred[m_g] = 1'b1;
            checks++;
            if (in_ready !== m_pred) begin
                errors++;
                $display("FAIL in_ready: got %b want %b at %0t", in_ready, m_pred, $time);
            end
            if (m_found && m_slot) begin
                m_h = flush_ch[m_g] ? 0 : mh[m_g];
                model_calc(int'($signed(xs[m_g])), m_h, m_y, m_sat);
                m_b.ch = m_g; m_b.y = m_y; m_b.sat = m_sat;
                sb.push_back(m_b);
                mh[m_g] = int'($signed(xs[m_g]));
                mptr    = (m_g + 1) % N;
                mov     = 1'b1;
            end else if (out_ready) begin
                mov = 1'b0;
            end
            for (int i = 0; i < N; i++)
                if (flush_ch[i] && !(m_found && m_slot && m_g == i)) mh[i] = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = '1; out_ready = 1'b1; flush_ch = '0; xs = '0;
        repeat (2) @(posedge clk);
        #2;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        if (y_out !== '0)       begin errors++; $display("FAIL reset y_out: got %0d want 0", y_out); end
        if (out_ch !== '0)      begin errors++; $display("FAIL reset out_ch: got %0d want 0", out_ch); end
        if (sat_event !== 1'b0) begin errors++; $display("FAIL reset sat_event: got %b want 0", sat_event); end
        if (in_ready !== '0)    begin errors++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = '0;
        tick();
    endtask

    task automatic test_basic();
        in_valid = 4'b0001; xs[0] = 16'sd1000;
        tick();
        checks++;
        if (out_valid !== 1'b1 || $signed(y_out) != 1000 || out_ch !== 2'd0) begin
            errors++; $display("FAIL basic first: got v=%b y=%0d ch=%0d want v=1 y=1000 ch=0", out_valid, $signed(y_out), out_ch);
        end
        tick();
        checks++;
        if ($signed(y_out) != 30 || sat_event !== 1'b0) begin
            errors++; $display("FAIL basic second: got y=%0d sat=%b want y=30 sat=0", $signed(y_out), sat_event);
        end
        in_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_all_channels();
        int prev;
        xs[0] = 16'sd100; xs[1] = -16'sd200; xs[2] = 16'sd500; xs[3] = 16'sd7000;
        in_valid = 4'hF;
        tick();
        prev = int'(out_ch);
        for (int c = 0; c < 7; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || int'(out_ch) != (prev + 1) % N) begin
                errors++; $display("FAIL rr order: got v=%b ch=%0d want v=1 ch=%0d", out_valid, out_ch, (prev + 1) % N);
            end
            prev = int'(out_ch);
        end
        in_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_saturation();
        in_valid = 4'b0010;
        xs[1] = 16'h8000;
        tick();
        xs[1] = 16'sd32767;
        tick();
        checks++;
        if ($signed(y_out) != 32767 || sat_event !== 1'b1 || out_ch !== 2'd1) begin
            errors++; $display("FAIL sat high: got y=%0d sat=%b ch=%0d want y=32767 sat=1 ch=1", $signed(y_out), sat_event, out_ch);
        end
        xs[1] = 16'sd0;
        tick();
        checks++;
        if ($signed(y_out) != -31784 || sat_event !== 1'b0) begin
            errors++; $display("FAIL sat zero: got y=%0d sat=%b want y=-31784 sat=0", $signed(y_out), sat_event);
        end
        in_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] y_hold;
        logic [1:0]    ch_hold;
        out_ready = 1'b0; in_valid = 4'b0001; xs[0] = 16'sd5; xs[3] = 16'sd77;
        tick();
        y_hold = y_out; ch_hold = out_ch;
        in_valid = 4'b1001;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (in_ready !== '0 || y_out !== y_hold || out_ch !== ch_hold || out_valid !== 1'b1) begin
                errors++; $display("FAIL stall: got rdy=%b y=%0d ch=%0d v=%b want rdy=0 y=%0d ch=%0d v=1",
                                   in_ready, y_out, out_ch, out_valid, y_hold, ch_hold);
            end
            tick();
        end
        out_ready = 1'b1;
        repeat (3) tick();
        in_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_flush();
        in_valid = 4'b0100; xs[2] = 16'sd1000;
        tick();
        in_valid = '0; flush_ch = 4'b0100;
        tick();
        flush_ch = '0; in_valid = 4'b0100; xs[2] = 16'sd200;
        tick();
        checks++;
        if ($signed(y_out) != 200) begin errors++; $display("FAIL flush alone: got y=%0d want 200", $signed(y_out)); end
        xs[2] = 16'sd300; flush_ch = 4'b0100;
        tick();
        checks++;
        if ($signed(y_out) != 300) begin errors++; $display("FAIL flush accept: got y=%0d want 300", $signed(y_out)); end
        flush_ch = '0;
        tick();
        checks++;
        if ($signed(y_out) != 9) begin errors++; $display("FAIL flush history: got y=%0d want 9", $signed(y_out)); end
        in_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 4'b0001; xs[0] = 16'sd123;
        tick();
        in_valid = 4'b0001;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y_out !== '0 || out_ch !== '0 || sat_event !== 1'b0 || in_ready !== '0) begin
            errors++; $display("FAIL async reset: got v=%b y=%0d ch=%0d sat=%b rdy=%b want all 0",
                               out_valid, y_out, out_ch, sat_event, in_ready);
        end
        repeat (2) tick();
        rst_n = 1'b1; out_ready = 1'b1; xs[0] = 16'sd1000;
        tick();
        checks++;
        if (out_valid !== 1'b1 || $signed(y_out) != 1000) begin
            errors++; $display("FAIL post reset: got v=%b y=%0d want v=1 y=1000", out_valid, $signed(y_out));
        end
        in_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush_ch  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            for (int i = 0; i < N; i++) xs[i] = SW'($urandom);
            tick();
        end
        in_valid = '0; flush_ch = '0; out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain: %0d beats outstanding, want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_channels();
        test_saturation();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
